id_stage_rf: RTL and testbench
==============================

# id_stage_rf

Parametrised instruction-decode pipeline stage with an integrated register file, successor to the fixed t0–t5/s0–s5 decode stage. Sits between the fetch stage and the execute stage. Reads two operands, with same-cycle write-back bypass, and produces the sign-extended immediate and jump target. Provides valid/ready handshaking on both sides and a one-bubble load-use interlock.

## Interface
- DATA_W, 32, operand/immediate width; legal values 32 or 64
- NREGS, 32, implemented registers; legal values 8, 16 or 32; reg 0 hardwired to 0
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts in_instr this cycle
- in_instr  in  32  MIPS instruction word
- wb_en  in  1  write-back strobe
- wb_addr  in  5  write-back register index
- wb_data  in  DATA_W  write-back value
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- out_instr  out  32  instruction passed downstream
- out_rd1 / out_rd2  out  DATA_W  rs / rt operand values
- out_imm  out  DATA_W  immediate or jump target
- out_jump  out  1  bundle is j
- out_illegal  out  1  unsupported opcode

## Operation
- Supported opcodes ([31:26]):
  - 000000 R-type
  - 100011 lw
  - 101011 sw
  - 000101 bne
  - 001000 addi
  - 000010 j
  - in_instr == 0 is NOP.
- advance = !out_valid || out_ready. Output registers load only when advance is true; otherwise all outputs hold.
- Hazard: asserted when out_valid=1, out_instr is lw with rt≠0, and in_valid=1, and either:
  - rt equals in_instr rs, or
  - in_instr is R-type/sw/bne and rt equals in_instr rt.
- in_ready = advance && !hazard.
- On advance:
  - in_valid && !hazard: load the decoded bundle; out_valid=1.
  - hazard: load a bubble: out_valid=1, out_instr=0, all data outputs 0. The instruction stays on the input.
  - !in_valid: out_valid=0; other outputs unchanged.
- Operand read: index ≥ NREGS or index 0 reads 0. If wb_en && wb_addr==index && index≠0 && index<NREGS, return wb_data (bypass); otherwise return the array value.
- Per-opcode outputs:
  - R-type, lw, sw, addi: rd1=R[rs], rd2=R[rt].
  - bne: rd1=R[rs], rd2=R[rt], imm=sext(instr[15:0])<<2.
  - lw, sw, addi: imm=sext(instr[15:0]) to DATA_W.
  - R-type: imm=0.
  - j: out_jump=1, rd1=rd2=0, imm=zero-extended {instr[25:0],2'b00}.
  - NOP: rd1, rd2, imm, jump, illegal all 0.
  - Any other opcode: out_illegal=1, rd1=rd2=imm=0.
- out_jump and out_illegal are recomputed on every load, never sticky.
- Register file write: if wb_en && wb_addr≠0 && wb_addr<NREGS, write on the clk edge. Otherwise the write is ignored. Writes are independent of handshake state.

## Timing
- Decode latency is 1 cycle from the accepting edge (in_valid && in_ready) to the bundle on the outputs.
- Throughput is 1 instruction/cycle without hazard. A load-use hazard costs exactly one bubble cycle.
- Write-back to read bypass takes effect on the same edge; a write at edge N is visible in the array from edge N+1.
- Reset (asynchronous, mid-operation allowed): out_valid, out_instr, out_rd1, out_rd2, out_imm, out_jump, out_illegal all go to 0 and all registers clear to 0. in_ready evaluates to 1 immediately because out_valid=0.
- Backpressure: with out_ready=0 and out_valid=1, in_ready=0 and a pending write-back still updates the array. When released, the held bundle is not re-read.
- A simultaneous hazard and out_ready=0 produces no bubble until advance is true.

## Test plan
- Reset, then write R9=5 and R10=−3. Issue add $8,$9,$10 (0x012A4020) → next cycle out_rd1=5, out_rd2=0xFFFFFFFD, out_imm=0.
- Same-edge bypass: wb_en=1, wb_addr=17, wb_data=0x1234 in the cycle lw $8,-4($17) is accepted → out_rd1=0x1234, out_imm=0xFFFFFFFC.
- bne $9,$10,-1 (0x152AFFFF) → out_imm=0xFFFFFFFC. j 0x0000010 (0x08000010) → out_jump=1, out_imm=0x40, rd1=rd2=0.
- Load-use: lw $8,0($9) followed by add $11,$8,$9 → in_ready=0 for 1 cycle, then a bubble (out_instr=0, out_valid=1), then the add is issued.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → outputs stable, in_ready=0, no instruction lost. NREGS=8 with read of index 12 → 0. Opcode 0x3F → out_illegal=1.
- Assert rst mid-stream → all outputs 0 asynchronously. After release, every register reads 0.

Source files
------------

// File: rtl/id_stage_rf.sv
// id_stage_rf: MIPS decode stage with bypassed register file, valid/ready handshake and load-use interlock
module id_stage_rf #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [DATA_W-1:0] out_rd1,
    output logic [DATA_W-1:0] out_rd2,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_jump,
    output logic              out_illegal
);
    localparam int AW = $clog2(NREGS);
    // index bits that must be zero for an implemented register
    localparam logic [4:0] HI = 5'(~(NREGS - 1));
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_J = 6'b000010;

    logic [DATA_W-1:0] regs [NREGS];
    logic [5:0]        op;
    logic [4:0]        rs, rt, lw_rt;
    logic              is_r, is_lw, is_sw, is_bne, is_addi, is_j, illegal;
    logic              hazard, advance, wb_ok;
    logic [DATA_W-1:0] rd1, rd2, imm;

    function automatic logic [DATA_W-1:0] rd(input logic [4:0] a);
        return (a == 5'd0 || (a & HI) != 5'd0) ? '0 :
               (wb_en && wb_addr == a) ? wb_data : regs[a[AW-1:0]];
    endfunction

    always_comb begin
        op      = in_instr[31:26];
        rs      = in_instr[25:21];
        rt      = in_instr[20:16];
        lw_rt   = out_instr[20:16];
        is_r    = op == OP_R;
        is_lw   = op == OP_LW;
        is_sw   = op == OP_SW;
        is_bne  = op == OP_BNE;
        is_addi = op == OP_ADDI;
        is_j    = op == OP_J;
        illegal = !(is_r || is_lw || is_sw || is_bne || is_addi || is_j);
        hazard  = out_valid && out_instr[31:26] == OP_LW && lw_rt != 5'd0 && in_valid &&
                  (lw_rt == rs || ((is_r || is_sw || is_bne) && lw_rt == rt));
        advance = !out_valid || out_ready;
        in_ready = advance && !hazard;
        wb_ok   = wb_en && wb_addr != 5'd0 && (wb_addr & HI) == 5'd0;
        rd1     = (is_j || illegal) ? '0 : rd(rs);
        rd2     = (is_j || illegal) ? '0 : rd(rt);
        imm     = is_bne ? {{(DATA_W-18){in_instr[15]}}, in_instr[15:0], 2'b00} :
                  (is_lw || is_sw || is_addi) ? {{(DATA_W-16){in_instr[15]}}, in_instr[15:0]} :
                  is_j ? {{(DATA_W-28){1'b0}}, in_instr[25:0], 2'b00} : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_rd1     <= '0;
            out_rd2     <= '0;
            out_imm     <= '0;
            out_jump    <= 1'b0;
            out_illegal <= 1'b0;
        end else if (advance) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_instr   <= hazard ? '0 : in_instr;
                out_rd1     <= hazard ? '0 : rd1;
                out_rd2     <= hazard ? '0 : rd2;
                out_imm     <= hazard ? '0 : imm;
                out_jump    <= !hazard && is_j;
                out_illegal <= !hazard && illegal;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_ok) begin
            regs[wb_addr[AW-1:0]] <= wb_data;
        end
    end
endmodule

// File: tb/tb_id_stage_rf.sv
// tb_id_stage_rf: directed and randomized checks of id_stage_rf (32 and 8 registers) against a behavioural model
module tb_id_stage_rf;
    typedef struct packed {
        logic        v;
        logic [31:0] ins, rd1, rd2, imm;
        logic        j, ill;
    } bnd_t;

    logic        clk = 0, rst = 1;
    logic        in_valid = 0, out_ready = 0, wb_en = 0;
    logic [31:0] in_instr = 0, wb_data = 0;
    logic [4:0]  wb_addr = 0;
    logic        in_ready, out_valid, out_jump, out_illegal;
    logic [31:0] out_instr, out_rd1, out_rd2, out_imm;
    logic        in_ready_8, out_valid_8, out_jump_8, out_illegal_8;
    logic [31:0] out_instr_8, out_rd1_8, out_rd2_8, out_imm_8;
    bnd_t        a32, a8, e = '0, e8 = '0;
    logic [31:0] m [32];
    int          vecs = 0, errs = 0;

    id_stage_rf dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_rd1(out_rd1), .out_rd2(out_rd2),
        .out_imm(out_imm), .out_jump(out_jump), .out_illegal(out_illegal)
    );

    id_stage_rf #(.DATA_W(32), .NREGS(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_8), .in_instr(in_instr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid_8),
        .out_ready(out_ready), .out_instr(out_instr_8), .out_rd1(out_rd1_8), .out_rd2(out_rd2_8),
        .out_imm(out_imm_8), .out_jump(out_jump_8), .out_illegal(out_illegal_8)
    );

    assign a32 = {out_valid, out_instr, out_rd1, out_rd2, out_imm, out_jump, out_illegal};
    assign a8  = {out_valid_8, out_instr_8, out_rd1_8, out_rd2_8, out_imm_8, out_jump_8, out_illegal_8};

    always #5 clk = ~clk;

    function automatic logic [31:0] rdm(input logic [4:0] a, input int n);
        if (a == 0 || int'(a) >= n) return 0;
        if (wb_en && wb_addr == a) return wb_data;
        return m[a];
    endfunction

    function automatic bnd_t dec(input logic [31:0] ins, input int n);
        bnd_t b = '0;
        int   s = $signed(ins[15:0]);
        b.v   = 1;
        b.ins = ins;
        case (ins[31:26])
            6'd0, 6'd35, 6'd43, 6'd5, 6'd8: begin
                b.rd1 = rdm(ins[25:21], n);
                b.rd2 = rdm(ins[20:16], n);
            end
            6'd2: begin
                b.j   = 1;
                b.imm = 32'(ins[25:0]) * 4;
            end
            default: b.ill = 1;
        endcase
        if (ins[31:26] inside {6'd35, 6'd43, 6'd8}) b.imm = s;
        if (ins[31:26] == 6'd5) b.imm = s * 4;
        return b;
    endfunction

    function automatic logic m_hz();
        logic [4:0] t = e.ins[20:16];
        return e.v && e.ins[31:26] == 6'd35 && t != 0 && in_valid &&
               (t == in_instr[25:21] || (in_instr[31:26] inside {6'd0, 6'd43, 6'd5} && t == in_instr[20:16]));
    endfunction

    function automatic logic [31:0] rnd_ins();
        logic [5:0] op;
        case ($urandom_range(0, 8))
            0: op = 6'd0;
            1, 2: op = 6'd35;
            3: op = 6'd43;
            4: op = 6'd5;
            5: op = 6'd8;
            6: op = 6'd2;
            7: op = 6'(32 + $urandom_range(0, 31));
            default: return 0;
        endcase
        return {op, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 16'($urandom)};
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) m[i] = 0;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                e  = '0;
                e8 = '0;
                for (int i = 0; i < 32; i++) m[i] = 0;
            end else begin
                if (!e.v || out_ready) begin
                    if (m_hz()) begin
                        e   = '0;
                        e.v = 1;
                        e8  = e;
                    end else if (in_valid) begin
                        e  = dec(in_instr, 32);
                        e8 = dec(in_instr, 8);
                    end else begin
                        e.v  = 0;
                        e8.v = 0;
                    end
                end
                if (wb_en && wb_addr != 0) m[wb_addr] = wb_data;
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] ins, input logic ordy,
                         input logic we = 0, input logic [4:0] wa = 0, input logic [31:0] wd = 0);
        in_valid = v; in_instr = ins; out_ready = ordy;
        wb_en = we; wb_addr = wa; wb_data = wd;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        vecs++;
        if (a32 !== '0 || a8 !== '0) begin errs++; $display("FAIL reset_outputs: got %h / %h want 0", a32, a8); end
        vecs++;
        if (in_ready !== 1'b1 || in_ready_8 !== 1'b1) begin errs++; $display("FAIL reset_in_ready: got %b/%b want 1", in_ready, in_ready_8); end
        @(negedge clk);
        rst = 1;
        tick;
    endtask

    task automatic test_directed;
        logic [31:0] t_ins [5] = '{32'h012A4020, 32'h152AFFFF, 32'h08000010, 32'hFD2A0000, 32'h2009FFFF};
        logic [97:0] t_exp [5] = '{
            {32'd5, 32'hFFFFFFFD, 32'd0, 2'b00},
            {32'd5, 32'hFFFFFFFD, 32'hFFFFFFFC, 2'b00},
            {32'd0, 32'd0, 32'h40, 2'b10},
            {32'd0, 32'd0, 32'd0, 2'b01},
            {32'd0, 32'd5, 32'hFFFFFFFF, 2'b00}};
        drive(0, 0, 1, 1, 9, 5); tick;
        drive(0, 0, 1, 1, 10, 32'hFFFFFFFD); tick;
        for (int i = 0; i < 5; i++) begin
            drive(1, t_ins[i], 1);
            vecs++;
            if (in_ready !== 1'b1) begin errs++; $display("FAIL decode_in_ready[%0d]: got %b want 1", i, in_ready); end
            tick;
            vecs++;
            if (a32 !== e || a8 !== e8) begin errs++; $display("FAIL decode_model[%0d]: got %h / %h want %h / %h", i, a32, a8, e, e8); end
            vecs++;
            if ({out_valid, out_rd1, out_rd2, out_imm, out_jump, out_illegal} !== {1'b1, t_exp[i]})
                begin errs++; $display("FAIL decode_value[%0d]: got %h %h %h j%b i%b want %h", i, out_rd1, out_rd2, out_imm, out_jump, out_illegal, t_exp[i]); end
        end
        drive(1, 32'h8E28FFFC, 1, 1, 17, 32'h1234); tick;
        vecs++;
        if (a32 !== e || out_rd1 !== 32'h1234 || out_imm !== 32'hFFFFFFFC)
            begin errs++; $display("FAIL bypass: got rd1 %h imm %h want 00001234 fffffffc", out_rd1, out_imm); end
        drive(1, 32'h018C0820, 1, 1, 12, 32'h77); tick;
        vecs++;
        if (out_rd1 !== 32'h77 || a32 !== e) begin errs++; $display("FAIL rf32_index12: got %h want 00000077", out_rd1); end
        vecs++;
        if (out_rd1_8 !== 0 || out_rd2_8 !== 0 || a8 !== e8) begin errs++; $display("FAIL rf8_index12: got %h %h want 0 0", out_rd1_8, out_rd2_8); end
    endtask

    task automatic test_hazard;
        for (int p = 0; p < 2; p++) begin
            drive(1, 32'h8D280000, 1); tick;
            for (int k = 0; k < 2 * p; k++) begin
                drive(1, 32'h01095820, 0);
                vecs++;
                if (in_ready !== 1'b0) begin errs++; $display("FAIL hazard_hold_ready[%0d]: got %b want 0", k, in_ready); end
                tick;
                vecs++;
                if (out_instr !== 32'h8D280000 || a32 !== e) begin errs++; $display("FAIL hazard_hold_out[%0d]: got %h want 8d280000", k, out_instr); end
            end
            drive(1, 32'h01095820, 1);
            vecs++;
            if (in_ready !== 1'b0 || in_ready_8 !== 1'b0) begin errs++; $display("FAIL hazard_stall[%0d]: got %b/%b want 0", p, in_ready, in_ready_8); end
            tick;
            vecs++;
            if (a32 !== {1'b1, 130'd0} || a8 !== {1'b1, 130'd0}) begin errs++; $display("FAIL hazard_bubble[%0d]: got %h want bubble", p, a32); end
            vecs++;
            if (in_ready !== 1'b1) begin errs++; $display("FAIL hazard_release[%0d]: got %b want 1", p, in_ready); end
            tick;
            vecs++;
            if (out_instr !== 32'h01095820 || a32 !== e) begin errs++; $display("FAIL hazard_issue[%0d]: got %h want 01095820", p, out_instr); end
        end
    endtask

    task automatic test_backpressure;
        bnd_t held;
        drive(1, 32'h20010005, 1); tick;
        held = e;
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h01291820, 0, k == 0, 9, 32'hAB);
            vecs++;
            if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, in_ready); end
            tick;
            vecs++;
            if (a32 !== held || held.ins !== 32'h20010005) begin errs++; $display("FAIL bp_stable[%0d]: got %h want %h", k, a32, held); end
        end
        drive(1, 32'h01291820, 1);
        vecs++;
        if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_release: got %b want 1", in_ready); end
        tick;
        vecs++;
        if (out_instr !== 32'h01291820 || out_rd1 !== 32'hAB || a32 !== e)
            begin errs++; $display("FAIL bp_after: got %h rd1 %h want 01291820 000000ab", out_instr, out_rd1); end
    endtask

    task automatic test_random;
        logic [31:0] ins = 0;
        logic        v = 0, er = 1;
        for (int n = 0; n < 400; n++) begin
            if (!(v && !er)) begin
                v   = $urandom_range(0, 3) != 0;
                ins = rnd_ins();
            end
            drive(v, ins, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 5'($urandom), $urandom);
            er = (!e.v || out_ready) && !m_hz();
            vecs++;
            if (in_ready !== er || in_ready_8 !== er) begin errs++; $display("FAIL rand_in_ready[%0d]: got %b/%b want %b", n, in_ready, in_ready_8, er); end
            tick;
            vecs++;
            if (a32 !== e || a8 !== e8) begin errs++; $display("FAIL rand_bundle[%0d]: got %h / %h want %h / %h", n, a32, a8, e, e8); end
        end
    endtask

    task automatic test_reset_mid;
        drive(1, 32'h20050007, 1, 1, 5, 32'hDEAD); tick;
        drive(0, 0, 1);
        #1 rst = 0;
        #1;
        vecs++;
        if (a32 !== '0 || a8 !== '0) begin errs++; $display("FAIL midreset_outputs: got %h / %h want 0", a32, a8); end
        vecs++;
        if (in_ready !== 1'b1) begin errs++; $display("FAIL midreset_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        rst = 1;
        for (int r = 1; r < 32; r++) begin
            drive(1, {6'd0, 5'(r), 5'(r), 16'h0820}, 1); tick;
            vecs++;
            if (out_valid !== 1'b1 || out_rd1 !== 0 || out_rd2 !== 0 || a32 !== e || a8 !== e8)
                begin errs++; $display("FAIL cleared_reg[%0d]: got %h %h want 0 0", r, out_rd1, out_rd2); end
        end
    endtask

    initial begin
        #1 rst = 0;
        test_reset;
        test_directed;
        test_hazard;
        test_backpressure;
        test_random;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
